// File: rtl/lin_rec_seq_gen_if.sv
// Output stream bundle for lin_rec_seq_gen.
//   seq        current term
//   seq_valid  seq holds a term offered to the consumer
//   seq_ready  consumer accepts seq when seq_valid & seq_ready
//   idx        count of accepted terms since reset/load
//   ovf        sticky overflow flag (zero when overflow tracking is not built)
// master: generator side, slave: consumer side.
interface lin_rec_seq_gen_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] seq;
  logic             seq_valid;
  logic             seq_ready;
  logic [CNT_W-1:0] idx;
  logic             ovf;

  modport master (
    output seq,
    output seq_valid,
    output idx,
    output ovf,
    input  seq_ready
  );

  modport slave (
    input  seq,
    input  seq_valid,
    input  idx,
    input  ovf,
    output seq_ready
  );
endinterface

// File: rtl/lin_rec_seq_gen.sv
// Linear-recurrence sequence generator. The next term is the sum of the history terms
// selected by a runtime tap mask; terms leave through a valid/ready stream.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start_i        IDLE -> RUN request
//   stop_i         RUN -> IDLE request (wins over start_i)
//   load_i         load seed_i into history, clear idx and ovf (state unchanged)
//   seed_i         DEPTH seeds, slice [i*WIDTH +: WIDTH] -> s[i], s[0] output first
//   taps_i         bit i set adds s[i] into the next term
//   sat_i          0 = wrap modulo 2^WIDTH, 1 = clamp to all-ones
//   seq_if         master side of the output stream (seq, seq_valid, seq_ready, idx, ovf)
// Build option: define SEQGEN_OVF_EN to implement the sticky overflow flag; otherwise
// ovf is tied to zero.
module lin_rec_seq_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   load_i,
  input  logic [DEPTH*WIDTH-1:0] seed_i,
  input  logic [DEPTH-1:0]       taps_i,
  input  logic                   sat_i,
  lin_rec_seq_gen_if.master      seq_if
);

  // Three guard bits hold the carry of up to eight WIDTH-bit addends.
  localparam int unsigned SumW = WIDTH + 3;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [SumW-1:0]  sum;
  logic             over;
  logic [WIDTH-1:0] nxt;
  logic             seq_valid;
  logic             xfer;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop has priority over start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i && !stop_i) state_d = StRun;
      StRun:   if (stop_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; valid follows the state register so reset drops it asynchronously
  always_comb begin
    seq_valid = (state_q == StRun);
  end

  assign xfer = seq_valid & seq_if.seq_ready;

  // Tapped sum at full precision, then wrap or clamp
  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (taps_i[i]) sum = sum + SumW'(hist_q[i]);
    end
    over = |sum[SumW-1:WIDTH];
    nxt  = (over && sat_i) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  // History and index update; a load overrides a coincident transfer
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) hist_d[i] = hist_q[i];
    idx_d = idx_q;
    if (load_i) begin
      for (int i = 0; i < int'(DEPTH); i++) hist_d[i] = seed_i[i*WIDTH +: WIDTH];
      idx_d = '0;
    end else if (xfer) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) hist_d[i] = hist_q[i+1];
      hist_d[DEPTH-1] = nxt;
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        hist_q[i] <= (i == 0) ? '0 : WIDTH'(1);
      end
      idx_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= hist_d[i];
      idx_q <= idx_d;
    end
  end

`ifdef SEQGEN_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow is judged on the unclamped sum, so it is flagged in both modes
  always_comb begin
    ovf_d = ovf_q;
    if (load_i) begin
      ovf_d = 1'b0;
    end else if (xfer && over) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign seq_if.ovf = ovf_q;
`else
  assign seq_if.ovf = 1'b0;
`endif

  assign seq_if.seq       = hist_q[0];
  assign seq_if.seq_valid = seq_valid;
  assign seq_if.idx       = idx_q;

endmodule
